quad_encoder_tx: RTL

QUAD_ENCODER_TX -- requirements
Module: quad_encoder_tx

---
 rtl/quad_encoder_tx_pkg.sv | 37 +++
 rtl/quad_encoder_tx_if.sv | 31 +++
 rtl/quad_encoder_tx_step_timer.sv | 46 ++++
 rtl/quad_encoder_tx.sv | 134 +++++++++++++
 4 files changed

// File: rtl/quad_encoder_tx_pkg.sv
// Shared definitions for the quadrature encoder transmitter.
//   quad_state_e : move-control FSM states (IDLE, DWELL, FINISH)
//   MIN_PERIOD   : smallest edge spacing in clk cycles; shorter requests are clamped up
//   phase_step() : next {A,B} phase in forward (B leads A) or reverse order
package quad_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DWELL  = 2'd1,
        FINISH = 2'd2
    } quad_state_e;

    localparam int MIN_PERIOD = 4;

    // Gray sequence {A,B}: 00 -> 01 -> 11 -> 10 -> 00 forward; reverse walks it backwards.
    function automatic logic [1:0] phase_step(input logic [1:0] ab, input logic reverse);
        logic [1:0] nxt;
        nxt = ab;
        if (!reverse) begin
            case (ab)
                2'b00:   nxt = 2'b01;
                2'b01:   nxt = 2'b11;
                2'b11:   nxt = 2'b10;
                default: nxt = 2'b00;
            endcase
        end else begin
            case (ab)
                2'b00:   nxt = 2'b10;
                2'b10:   nxt = 2'b11;
                2'b11:   nxt = 2'b01;
                default: nxt = 2'b00;
            endcase
        end
        return nxt;
    endfunction

endpackage

// File: rtl/quad_encoder_tx_if.sv
// Bundle of the command handshake and encoder outputs of quad_encoder_tx.
//   master : command source (drives cmd_*, abort; observes status/encoder)
//   slave  : the encoder transmitter
// Handshake: a command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both high; cmd_ready is only high while the block is idle.
interface quad_encoder_tx_if #(
    parameter int STEP_W   = 10,
    parameter int PERIOD_W = 16,
    parameter int POS_W    = 16
);
    logic                       cmd_valid;
    logic                       cmd_ready;
    logic signed [STEP_W-1:0]   cmd_steps;
    logic        [PERIOD_W-1:0] cmd_period;
    logic                       abort;
    logic                       quadA;
    logic                       quadB;
    logic                       busy;
    logic                       done;
    logic signed [POS_W-1:0]    position;

    modport master (
        output cmd_valid, cmd_steps, cmd_period, abort,
        input  cmd_ready, quadA, quadB, busy, done, position
    );

    modport slave (
        input  cmd_valid, cmd_steps, cmd_period, abort,
        output cmd_ready, quadA, quadB, busy, done, position
    );
endinterface

// File: rtl/quad_encoder_tx_step_timer.sv
// quad_step_timer: reloadable period down-counter pacing the encoder edges.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : count while high (move in progress)
//   load       : start a new move; latches period
//   period     : edge spacing in clk cycles (caller guarantees >= 2)
//   tick       : one-cycle pulse in the cycle before each edge becomes visible
// The edge is registered, so the tick has to lead it by one cycle. The first
// interval is therefore loaded with period-2 (the load cycle itself counts as
// cycle 0 of the move) and every later interval with period-1.
module quad_step_timer #(
    parameter int PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                load,
    input  logic [PERIOD_W-1:0] period,
    output logic                tick
);
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W-1:0] per_q, per_d;

    assign tick = en && (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        per_d = per_q;
        if (load) begin
            cnt_d = period - PERIOD_W'(2);
            per_d = period;
        end else if (en) begin
            if (cnt_q == '0) cnt_d = per_q - PERIOD_W'(1);
            else             cnt_d = cnt_q - PERIOD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            per_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            per_q <= per_d;
        end
    end
endmodule

// File: rtl/quad_encoder_tx.sv
// quad_encoder_tx: emits a commanded number of quadrature edges on quadA/quadB
// at a programmable spacing and tracks the signed edge count in position.
//   clk, rst_n           : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready  : command handshake (ready only in IDLE)
//   cmd_steps            : signed edge count; sign selects direction
//   cmd_period           : clk cycles between edges, clamped to >= MIN_PERIOD
//   abort                : end the move after the current phase
//   quadA, quadB         : registered encoder phases
//   busy, done           : move in progress / one-cycle end-of-move pulse
//   position             : signed edge count since reset, wraps
//   state_dbg            : current FSM state for observation
module quad_encoder_tx
    import quad_pkg::*;
#(
    parameter int STEP_W   = 10,
    parameter int PERIOD_W = 16,
    parameter int POS_W    = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic signed [STEP_W-1:0]   cmd_steps,
    input  logic        [PERIOD_W-1:0] cmd_period,
    input  logic                       abort,
    output logic                       quadA,
    output logic                       quadB,
    output logic                       busy,
    output logic                       done,
    output logic signed [POS_W-1:0]    position,
    output quad_state_e                state_dbg
);
    localparam logic [PERIOD_W-1:0] MIN_P = PERIOD_W'(MIN_PERIOD);

    quad_state_e         state_q, state_d;
    logic [1:0]          ab_q, ab_d;
    logic [POS_W-1:0]    pos_q, pos_d;
    logic [STEP_W-1:0]   rem_q, rem_d;
    logic                dir_q, dir_d;   // 1 = negative (reverse phase order)
    logic                done_q, done_d;

    logic                accept;
    logic                tick;
    logic [STEP_W-1:0]   steps_raw;
    logic [STEP_W-1:0]   steps_mag;
    logic [PERIOD_W-1:0] eff_period;

    assign accept    = cmd_valid && (state_q == IDLE);
    assign steps_raw = cmd_steps;
    // Unsigned magnitude: the most negative command maps to 2^(STEP_W-1) cleanly.
    assign steps_mag = steps_raw[STEP_W-1] ? (~steps_raw + STEP_W'(1)) : steps_raw;
    assign eff_period = (cmd_period < MIN_P) ? MIN_P : cmd_period;

    quad_step_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (state_q == DWELL),
        .load   (accept),
        .period (eff_period),
        .tick   (tick)
    );

    always_comb begin
        state_d = state_q;
        ab_d    = ab_q;
        pos_d   = pos_q;
        rem_d   = rem_q;
        dir_d   = dir_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    rem_d = steps_mag;
                    dir_d = steps_raw[STEP_W-1];
                    if (steps_mag == '0) begin
                        state_d = FINISH;
                        done_d  = 1'b1;
                    end else begin
                        state_d = DWELL;
                    end
                end
            end
            DWELL: begin
                if (rem_q == '0) begin
                    // Last edge went out in the previous cycle (or abort coincided with it).
                    state_d = FINISH;
                    done_d  = 1'b1;
                end else if (tick) begin
                    ab_d  = phase_step(ab_q, dir_q);
                    pos_d = dir_q ? (pos_q - POS_W'(1)) : (pos_q + POS_W'(1));
                    // An abort landing on an edge lets the edge out, then ends via rem==0.
                    rem_d = abort ? '0 : (rem_q - STEP_W'(1));
                end else if (abort) begin
                    state_d = FINISH;
                    done_d  = 1'b1;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ab_q    <= 2'b00;
            pos_q   <= '0;
            rem_q   <= '0;
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ab_q    <= ab_d;
            pos_q   <= pos_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign quadA     = ab_q[1];
    assign quadB     = ab_q[0];
    assign position  = pos_q;
    assign state_dbg = state_q;
endmodule
